// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
// ysyx_23060077_riscv_mem_arbiter
// Shares one AXI-lite style read/write master between the IFU fetch port and
// the LSU load/store ports. One transaction is in flight at a time. The
// address, data and strobe of the granted request are captured in registers
// and held there for the whole transaction.
// Optional feature: define ARB_RR_EN so that IFU and LSU reads alternate on a
// tie. Stores always keep top priority. Without ARB_RR_EN the priority is
// fixed: store, then load, then fetch.
`timescale 1ns/1ps
module ysyx_23060077_riscv_mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_r_valid_i,
  input  logic [DATA_WIDTH-1:0] ifu_r_addr_i,
  output logic                  ifu_r_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_r_data_o,
  input  logic                  lsu_r_valid_i,
  input  logic [DATA_WIDTH-1:0] lsu_r_addr_i,
  output logic                  lsu_r_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_r_data_o,
  input  logic                  lsu_w_valid_i,
  input  logic [DATA_WIDTH-1:0] lsu_w_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_w_data_i,
  input  logic [2:0]            lsu_w_strb_i,
  output logic                  lsu_w_ready_o,
  output logic                  mem_r_valid_o,
  output logic [DATA_WIDTH-1:0] mem_r_addr_o,
  input  logic                  mem_r_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_r_data_i,
  output logic                  mem_w_valid_o,
  output logic [DATA_WIDTH-1:0] mem_w_addr_o,
  output logic [DATA_WIDTH-1:0] mem_w_data_o,
  output logic [2:0]            mem_w_strb_o,
  input  logic                  mem_w_ready_i,
  output logic [1:0]            arb_owner_o
);

  // The state encoding doubles as the owner code seen on arb_owner_o.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFU_RD = 2'd1,
    ST_LSU_RD = 2'd2,
    ST_LSU_WR = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            strb_q, strb_d;
  logic                  lsu_r_wins_tie_s;

`ifdef ARB_RR_EN
  // Set when the most recent read grant went to the IFU.
  logic last_ifu_q, last_ifu_d;

  // Decide the IFU/LSU read tie from the previous read winner.
  always_comb begin
    lsu_r_wins_tie_s = last_ifu_q;
  end
`else
  // Decide the IFU/LSU read tie by fixed priority: the load wins.
  always_comb begin
    lsu_r_wins_tie_s = 1'b1;
  end
`endif

  // Work out the next state and capture the granted request in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
`ifdef ARB_RR_EN
    last_ifu_d = last_ifu_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lsu_w_valid_i) begin
          state_d = ST_LSU_WR;
          addr_d  = lsu_w_addr_i;
          data_d  = lsu_w_data_i;
          strb_d  = lsu_w_strb_i;
        end else if (lsu_r_valid_i && (!ifu_r_valid_i || lsu_r_wins_tie_s)) begin
          state_d = ST_LSU_RD;
          addr_d  = lsu_r_addr_i;
          data_d  = {DATA_WIDTH{1'b0}};
          strb_d  = 3'd0;
`ifdef ARB_RR_EN
          last_ifu_d = 1'b0;
`endif
        end else if (ifu_r_valid_i) begin
          state_d = ST_IFU_RD;
          addr_d  = ifu_r_addr_i;
          data_d  = {DATA_WIDTH{1'b0}};
          strb_d  = 3'd0;
`ifdef ARB_RR_EN
          last_ifu_d = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IFU_RD, ST_LSU_RD: begin
        // A stray write completion does not end a read.
        if (mem_r_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_LSU_WR: begin
        // A stray read completion does not end a write.
        if (mem_w_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registers for the state and the captured request; reset clears them all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= {DATA_WIDTH{1'b0}};
      data_q  <= {DATA_WIDTH{1'b0}};
      strb_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

`ifdef ARB_RR_EN
  // Last-winner flag; after reset the load counts as the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ifu_q <= 1'b0;
    end else begin
      last_ifu_q <= last_ifu_d;
    end
  end
`endif

  // The valids come straight from the state register. Only the current owner
  // may see the completion pulse, which passes through combinationally.
  assign arb_owner_o   = state_q;
  assign mem_r_valid_o = (state_q == ST_IFU_RD) || (state_q == ST_LSU_RD);
  assign mem_w_valid_o = (state_q == ST_LSU_WR);
  assign mem_r_addr_o  = addr_q;
  assign mem_w_addr_o  = addr_q;
  assign mem_w_data_o  = data_q;
  assign mem_w_strb_o  = strb_q;
  assign ifu_r_ready_o = (state_q == ST_IFU_RD) && mem_r_ready_i;
  assign lsu_r_ready_o = (state_q == ST_LSU_RD) && mem_r_ready_i;
  assign lsu_w_ready_o = (state_q == ST_LSU_WR) && mem_w_ready_i;
  assign ifu_r_data_o  = mem_r_data_i;
  assign lsu_r_data_o  = mem_r_data_i;

endmodule

// File: tb/tb_ysyx_23060077_riscv_mem_arbiter.sv
// Self-checking bench for ysyx_23060077_riscv_mem_arbiter: directed scenarios
// followed by randomized traffic compared against a transaction-level model.
`timescale 1ns/1ps
module tb_ysyx_23060077_riscv_mem_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_r_valid_i, lsu_r_valid_i, lsu_w_valid_i;
  logic [DW-1:0] ifu_r_addr_i, lsu_r_addr_i, lsu_w_addr_i, lsu_w_data_i;
  logic [2:0]    lsu_w_strb_i;
  logic          ifu_r_ready_o, lsu_r_ready_o, lsu_w_ready_o;
  logic [DW-1:0] ifu_r_data_o, lsu_r_data_o;
  logic          mem_r_valid_o, mem_w_valid_o, mem_r_ready_i, mem_w_ready_i;
  logic [DW-1:0] mem_r_addr_o, mem_r_data_i, mem_w_addr_o, mem_w_data_o;
  logic [2:0]    mem_w_strb_o;
  logic [1:0]    arb_owner_o;

  int errors = 0;
  int checks = 0;

  ysyx_23060077_riscv_mem_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i),
    .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
    .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o),
    .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i),
    .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i),
    .lsu_w_ready_o(lsu_w_ready_o),
    .mem_r_valid_o(mem_r_valid_o), .mem_r_addr_o(mem_r_addr_o),
    .mem_r_ready_i(mem_r_ready_i), .mem_r_data_i(mem_r_data_i),
    .mem_w_valid_o(mem_w_valid_o), .mem_w_addr_o(mem_w_addr_o),
    .mem_w_data_o(mem_w_data_o), .mem_w_strb_o(mem_w_strb_o),
    .mem_w_ready_i(mem_w_ready_i), .arb_owner_o(arb_owner_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ifu_r_valid_i = 1'b0; ifu_r_addr_i = '0;
    lsu_r_valid_i = 1'b0; lsu_r_addr_i = '0;
    lsu_w_valid_i = 1'b0; lsu_w_addr_i = '0; lsu_w_data_i = '0; lsu_w_strb_i = 3'd0;
    mem_r_ready_i = 1'b0; mem_r_data_i = '0; mem_w_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    mem_r_ready_i = 1'b1; mem_w_ready_i = 1'b1;
    #1;
    checks++;
    if ({arb_owner_o, mem_r_valid_o, mem_w_valid_o, ifu_r_ready_o, lsu_r_ready_o, lsu_w_ready_o} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl: got owner=%0d rv=%b wv=%b rdy=%b%b%b required all 0",
        arb_owner_o, mem_r_valid_o, mem_w_valid_o, ifu_r_ready_o, lsu_r_ready_o, lsu_w_ready_o);
    end
    checks++;
    if ({mem_r_addr_o, mem_w_data_o, mem_w_strb_o} !== {DW*2+3{1'b0}}) begin
      errors++; $display("FAIL reset_regs: got addr=%h data=%h strb=%0d required 0", mem_r_addr_o, mem_w_data_o, mem_w_strb_o);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_ifu_single();
    int pulses;
    do_reset();
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0000;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_r_ready_i = (c == 2);
      mem_r_data_i  = 32'h0000_0413;
      ifu_r_addr_i  = 32'h1234_5678;
      #1;
      checks++;
      if (arb_owner_o !== 2'd1 || mem_r_valid_o !== 1'b1 || mem_r_addr_o !== 32'h8000_0000) begin
        errors++; $display("FAIL ifu_busy[%0d]: got owner=%0d rv=%b addr=%h required 1 1 80000000", c, arb_owner_o, mem_r_valid_o, mem_r_addr_o);
      end
      if (ifu_r_ready_o) pulses++;
    end
    checks++;
    if (pulses !== 1 || ifu_r_data_o !== 32'h0000_0413) begin
      errors++; $display("FAIL ifu_pulse: got pulses=%0d data=%h required 1 00000413", pulses, ifu_r_data_o);
    end
    @(negedge clk);
    ifu_r_valid_i = 1'b0; mem_r_ready_i = 1'b0;
    #1;
    checks++;
    if (arb_owner_o !== 2'd0 || mem_r_valid_o !== 1'b0) begin
      errors++; $display("FAIL ifu_done: got owner=%0d rv=%b required 0 0", arb_owner_o, mem_r_valid_o);
    end
  endtask

  task automatic test_write_priority();
    do_reset();
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0004;
    lsu_w_valid_i = 1'b1; lsu_w_addr_i = 32'h8000_0100; lsu_w_data_i = 32'hDEAD_BEEF; lsu_w_strb_i = 3'd4;
    @(negedge clk);
    mem_w_ready_i = 1'b1;
    #1;
    checks++;
    if (arb_owner_o !== 2'd3 || mem_w_valid_o !== 1'b1 || mem_r_valid_o !== 1'b0 ||
        mem_w_addr_o !== 32'h8000_0100 || mem_w_data_o !== 32'hDEAD_BEEF || mem_w_strb_o !== 3'd4) begin
      errors++; $display("FAIL wr_grant: got owner=%0d wv=%b addr=%h data=%h strb=%0d required 3 1 80000100 deadbeef 4",
        arb_owner_o, mem_w_valid_o, mem_w_addr_o, mem_w_data_o, mem_w_strb_o);
    end
    checks++;
    if (lsu_w_ready_o !== 1'b1 || ifu_r_ready_o !== 1'b0) begin
      errors++; $display("FAIL wr_ready: got w=%b ifu=%b required 1 0", lsu_w_ready_o, ifu_r_ready_o);
    end
    @(negedge clk);
    lsu_w_valid_i = 1'b0; mem_w_ready_i = 1'b0;
    #1;
    checks++;
    if (arb_owner_o !== 2'd0) begin
      errors++; $display("FAIL wr_gap: got owner=%0d required 0", arb_owner_o);
    end
    @(negedge clk);
    mem_r_ready_i = 1'b1; mem_r_data_i = 32'h0000_0013;
    #1;
    checks++;
    if (arb_owner_o !== 2'd1 || mem_r_addr_o !== 32'h8000_0004 || ifu_r_ready_o !== 1'b1) begin
      errors++; $display("FAIL wr_then_ifu: got owner=%0d addr=%h rdy=%b required 1 80000004 1", arb_owner_o, mem_r_addr_o, ifu_r_ready_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [1:0] exp_owner;
    do_reset();
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0010;
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0200;
    for (int g = 0; g < 6; g++) begin
`ifdef ARB_RR_EN
      exp_owner = (g % 2 == 0) ? 2'd1 : 2'd2;
`else
      exp_owner = 2'd2;
`endif
      @(negedge clk);
      mem_r_ready_i = 1'b1;
      #1;
      checks++;
      if (arb_owner_o !== exp_owner || (exp_owner == 2'd1 ? ifu_r_ready_o : lsu_r_ready_o) !== 1'b1) begin
        errors++; $display("FAIL contend[%0d]: got owner=%0d required %0d", g, arb_owner_o, exp_owner);
      end
      @(negedge clk);
      mem_r_ready_i = 1'b0;
      #1;
      checks++;
      if (arb_owner_o !== 2'd0) begin
        errors++; $display("FAIL contend_gap[%0d]: got owner=%0d required 0", g, arb_owner_o);
      end
    end
    clear_inputs();
  endtask

  task automatic test_wrong_ready();
    do_reset();
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0020;
    @(negedge clk);
    ifu_r_valid_i = 1'b0;
    lsu_w_valid_i = 1'b1; lsu_w_addr_i = 32'h8000_0300;
    mem_w_ready_i = 1'b1;
    #1;
    checks++;
    if (lsu_w_ready_o !== 1'b0 || ifu_r_ready_o !== 1'b0 || arb_owner_o !== 2'd1) begin
      errors++; $display("FAIL stray_wready: got wr=%b ifu=%b owner=%0d required 0 0 1", lsu_w_ready_o, ifu_r_ready_o, arb_owner_o);
    end
    @(negedge clk);
    mem_w_ready_i = 1'b0;
    #1;
    checks++;
    if (arb_owner_o !== 2'd1 || mem_r_addr_o !== 32'h8000_0020) begin
      errors++; $display("FAIL stray_hold: got owner=%0d addr=%h required 1 80000020", arb_owner_o, mem_r_addr_o);
    end
    mem_r_ready_i = 1'b1;
    #1;
    checks++;
    if (ifu_r_ready_o !== 1'b1) begin
      errors++; $display("FAIL stray_done: got ifu_ready=%b required 1", ifu_r_ready_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0400;
    @(negedge clk);
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h8000_0030;
    #1;
    checks++;
    if (arb_owner_o !== 2'd2) begin
      errors++; $display("FAIL rstmid_grant: got owner=%0d required 2", arb_owner_o);
    end
    @(negedge clk);
    rst = 1'b1; mem_r_ready_i = 1'b1;
    #1;
    checks++;
    if (arb_owner_o !== 2'd0 || mem_r_valid_o !== 1'b0 || lsu_r_ready_o !== 1'b0 || mem_r_addr_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_abort: got owner=%0d rv=%b rdy=%b addr=%h required 0 0 0 0",
        arb_owner_o, mem_r_valid_o, lsu_r_ready_o, mem_r_addr_o);
    end
    @(negedge clk);
    rst = 1'b0; mem_r_ready_i = 1'b0; lsu_r_valid_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (arb_owner_o !== 2'd1 || mem_r_addr_o !== 32'h8000_0030) begin
      errors++; $display("FAIL rstmid_after: got owner=%0d addr=%h required 1 80000030", arb_owner_o, mem_r_addr_o);
    end
    mem_r_ready_i = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_drop_valid();
    do_reset();
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0500;
    @(negedge clk);
    lsu_r_valid_i = 1'b0; lsu_r_addr_i = 32'h0BAD_0BAD;
    @(negedge clk);
    #1;
    checks++;
    if (arb_owner_o !== 2'd2 || mem_r_addr_o !== 32'h8000_0500) begin
      errors++; $display("FAIL drop_hold: got owner=%0d addr=%h required 2 80000500", arb_owner_o, mem_r_addr_o);
    end
    mem_r_ready_i = 1'b1; mem_r_data_i = 32'hCAFE_F00D;
    #1;
    checks++;
    if (lsu_r_ready_o !== 1'b1 || lsu_r_data_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL drop_done: got rdy=%b data=%h required 1 cafef00d", lsu_r_ready_o, lsu_r_data_o);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Randomized traffic against a transaction-level model: requesters raise a
  // request and keep it until their completion pulse; the memory answers after
  // a random delay and sometimes sends completions of the wrong kind.
  task automatic test_random(input int cycles);
    int         m_owner;
    logic [31:0] m_addr, m_data;
    logic [2:0]  m_strb;
    bit         m_last_ifu;
    int         lat;
    bit         e_i, e_r, e_w;
    bit         done_i, done_r, done_w;
    do_reset();
    m_owner = 0; m_last_ifu = 1'b0; lat = 0;
    m_addr = '0; m_data = '0; m_strb = '0;
    done_i = 0; done_r = 0; done_w = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done_i) ifu_r_valid_i = 1'b0;
      if (done_r) lsu_r_valid_i = 1'b0;
      if (done_w) lsu_w_valid_i = 1'b0;
      done_i = 0; done_r = 0; done_w = 0;
      if (!ifu_r_valid_i && $urandom_range(0, 2) == 0) begin
        ifu_r_valid_i = 1'b1; ifu_r_addr_i = $urandom;
      end
      if (!lsu_r_valid_i && $urandom_range(0, 2) == 0) begin
        lsu_r_valid_i = 1'b1; lsu_r_addr_i = $urandom;
      end
      if (!lsu_w_valid_i && $urandom_range(0, 4) == 0) begin
        lsu_w_valid_i = 1'b1; lsu_w_addr_i = $urandom; lsu_w_data_i = $urandom;
        case ($urandom_range(0, 2))
          0: lsu_w_strb_i = 3'd1;
          1: lsu_w_strb_i = 3'd2;
          default: lsu_w_strb_i = 3'd4;
        endcase
      end
      mem_r_data_i  = $urandom;
      mem_r_ready_i = (m_owner == 1 || m_owner == 2) ? (lat == 0) : ($urandom_range(0, 3) == 0);
      mem_w_ready_i = (m_owner == 3) ? (lat == 0) : ($urandom_range(0, 3) == 0);
      e_i = (m_owner == 1) && mem_r_ready_i;
      e_r = (m_owner == 2) && mem_r_ready_i;
      e_w = (m_owner == 3) && mem_w_ready_i;
      #1;
      checks++;
      if (arb_owner_o !== 2'(m_owner) || mem_r_valid_o !== (m_owner == 1 || m_owner == 2) || mem_w_valid_o !== (m_owner == 3)) begin
        errors++; $display("FAIL rnd_state[%0d]: got owner=%0d rv=%b wv=%b required owner=%0d", n, arb_owner_o, mem_r_valid_o, mem_w_valid_o, m_owner);
      end
      checks++;
      if ({ifu_r_ready_o, lsu_r_ready_o, lsu_w_ready_o} !== {e_i, e_r, e_w}) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b%b%b required %b%b%b", n, ifu_r_ready_o, lsu_r_ready_o, lsu_w_ready_o, e_i, e_r, e_w);
      end
      if (m_owner != 0) begin
        checks++;
        if (mem_r_addr_o !== m_addr || mem_w_addr_o !== m_addr) begin
          errors++; $display("FAIL rnd_addr[%0d]: got %h required %h", n, mem_r_addr_o, m_addr);
        end
      end
      if (m_owner == 3) begin
        checks++;
        if (mem_w_data_o !== m_data || mem_w_strb_o !== m_strb) begin
          errors++; $display("FAIL rnd_wdata[%0d]: got %h/%0d required %h/%0d", n, mem_w_data_o, mem_w_strb_o, m_data, m_strb);
        end
      end
      if (e_i || e_r) begin
        checks++;
        if (ifu_r_data_o !== mem_r_data_i || lsu_r_data_o !== mem_r_data_i) begin
          errors++; $display("FAIL rnd_rdata[%0d]: got %h required %h", n, e_i ? ifu_r_data_o : lsu_r_data_o, mem_r_data_i);
        end
      end
      @(posedge clk);
      if (m_owner == 0) begin
        if (lsu_w_valid_i) begin
          m_owner = 3; m_addr = lsu_w_addr_i; m_data = lsu_w_data_i; m_strb = lsu_w_strb_i;
        end else if (lsu_r_valid_i && ifu_r_valid_i) begin
`ifdef ARB_RR_EN
          m_owner = m_last_ifu ? 2 : 1;
`else
          m_owner = 2;
`endif
        end else if (lsu_r_valid_i) begin
          m_owner = 2;
        end else if (ifu_r_valid_i) begin
          m_owner = 1;
        end else begin
          m_owner = 0;
        end
        if (m_owner == 1) begin m_addr = ifu_r_addr_i; m_last_ifu = 1'b1; end
        if (m_owner == 2) begin m_addr = lsu_r_addr_i; m_last_ifu = 1'b0; end
        lat = $urandom_range(0, 3);
      end else if (e_i || e_r || e_w) begin
        m_owner = 0;
        done_i = e_i; done_r = e_r; done_w = e_w;
      end else begin
        lat = lat - 1;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ifu_single();
    test_write_priority();
    test_contention();
    test_wrong_ready();
    test_reset_mid();
    test_drop_valid();
    test_random(2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
